// File: rtl/ltl_nfa_engine_if.sv
// ltl_nfa_engine_if: symbol stream, configuration port and report outputs of the NFA engine
interface ltl_nfa_engine_if #(
  parameter int N_STE = 9,
  parameter int SYM_W = 8,
  parameter int CNT_W = 16
);
  localparam int AW = (SYM_W > 5) ? SYM_W : 5;
  logic             run;
  logic             flush;
  logic             sym_valid;
  logic [SYM_W-1:0] symbols;
  logic             cfg_we;
  logic [1:0]       cfg_sel;
  logic [AW-1:0]    cfg_addr;
  logic [N_STE-1:0] cfg_wdata;
  logic             cfg_err;
  logic [N_STE-1:0] active;
  logic [N_STE-1:0] report_vec;
  logic             report_valid;
  logic [N_STE-1:0] report_sticky;
  logic [CNT_W-1:0] report_cnt;
  modport master (
    output run, flush, sym_valid, symbols, cfg_we, cfg_sel, cfg_addr, cfg_wdata,
    input  cfg_err, active, report_vec, report_valid, report_sticky, report_cnt
  );
  modport slave (
    input  run, flush, sym_valid, symbols, cfg_we, cfg_sel, cfg_addr, cfg_wdata,
    output cfg_err, active, report_vec, report_valid, report_sticky, report_cnt
  );
endinterface

// File: rtl/ltl_nfa_engine.sv
// ltl_nfa_engine: homogeneous-STE NFA with configurable match/edge/start tables and report accounting
module ltl_nfa_engine #(
  parameter int N_STE = 9,
  parameter int SYM_W = 8,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  ltl_nfa_engine_if.slave bus
);
  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic [N_STE-1:0] r_match [2**SYM_W];
  logic [N_STE-1:0] r_edge [N_STE];
  logic [N_STE-1:0] r_start_sod, r_start_all, r_rep_mask, r_active, r_sticky;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sod, r_err;
  logic [N_STE-1:0] w_follow, w_enable, w_next, w_next_rep;
  logic [31:0]      w_addr;
  logic             w_step, w_addr_ok, w_cfg_ok;

  // reset asserts at once and releases on a clock edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rst_sync <= '0;
    else r_rst_sync <= {r_rst_sync[0], 1'b1};
  assign w_rst_n = r_rst_sync[1];

  // union of successor sets of every active STE
  always_comb begin
    w_follow = '0;
    for (int j = 0; j < N_STE; j++) w_follow = w_follow | (r_active[j] ? r_edge[j] : '0);
  end

  assign w_step     = bus.run & bus.sym_valid & ~bus.flush;
  assign w_enable   = (r_start_sod & {N_STE{r_sod}}) | r_start_all | w_follow;
  assign w_next     = w_enable & r_match[bus.symbols];
  assign w_next_rep = w_next & r_rep_mask;
  assign w_addr     = 32'(bus.cfg_addr);
  assign w_addr_ok  = (bus.cfg_sel == 2'd0) ? (w_addr < 32'(2**SYM_W)) :
                      (bus.cfg_sel == 2'd1) ? (w_addr < 32'(N_STE)) : 1'b1;
  assign w_cfg_ok   = bus.cfg_we & ~bus.run & w_addr_ok;

  // configuration tables, writable only while the engine is stopped
  always_ff @(posedge clk or negedge w_rst_n)
    if (!w_rst_n) begin
      for (int s = 0; s < 2**SYM_W; s++) r_match[s] <= '0;
      for (int j = 0; j < N_STE; j++) r_edge[j] <= '0;
      r_start_sod <= '0;
      r_start_all <= '0;
      r_rep_mask  <= '0;
    end else if (w_cfg_ok) begin
      if (bus.cfg_sel == 2'd0) r_match[bus.cfg_addr[SYM_W-1:0]] <= bus.cfg_wdata;
      if (bus.cfg_sel == 2'd1)
        for (int j = 0; j < N_STE; j++) if (w_addr == 32'(j)) r_edge[j] <= bus.cfg_wdata;
      if (bus.cfg_sel == 2'd2 && !bus.cfg_addr[0]) r_start_sod <= bus.cfg_wdata;
      if (bus.cfg_sel == 2'd2 && bus.cfg_addr[0]) r_start_all <= bus.cfg_wdata;
      if (bus.cfg_sel == 2'd3) r_rep_mask <= bus.cfg_wdata;
    end

  // active-state advance; reports are accounted once per step that produces them
  always_ff @(posedge clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_active <= '0;
      r_sticky <= '0;
      r_cnt    <= '0;
      r_sod    <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      r_err <= bus.cfg_we & ~w_cfg_ok;
      if (bus.flush) begin
        r_active <= '0;
        r_sticky <= '0;
        r_cnt    <= '0;
        r_sod    <= 1'b1;
      end else if (w_step) begin
        r_active <= w_next;
        r_sod    <= 1'b0;
        r_sticky <= r_sticky | w_next_rep;
        if ((|w_next_rep) && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
      end
    end

  assign bus.active        = r_active;
  assign bus.report_vec    = r_active & r_rep_mask;
  assign bus.report_valid  = |(r_active & r_rep_mask);
  assign bus.report_sticky = r_sticky;
  assign bus.report_cnt    = r_cnt;
  assign bus.cfg_err       = r_err;
endmodule
